// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizing constants and address-width helper
// Purpose: defaults shared by fifo_ctrl and ram_dp_FIFO, plus fifo_aw().
// Ports: none (package).
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 32;
    localparam int FIFO_SIZE_DEF  = 8;

    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - request/RAM-control/status bundle of the FIFO controller
// Purpose: groups the push/pop requests, RAM control and status flags.
// Signals: wrreq, rdreq (requester -> ctrl); wren, rden, wraddress, rdaddress,
//          full, empty, almost_full, almost_empty, usedw, rd_valid (ctrl -> requester/RAM).
//          overflow, underflow exist only when FIFO_ERR_FLAGS_EN is defined.
// Modports: master = requester side, slave = fifo_ctrl side.
interface fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int AW = fifo_aw(FIFO_DEPTH_DEF)
);
    logic          wrreq;
    logic          rdreq;
    logic          wren;
    logic          rden;
    logic [AW-1:0] wraddress;
    logic [AW-1:0] rdaddress;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   usedw;
    logic          rd_valid;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;

    modport master (
        output wrreq, rdreq,
        input  wren, rden, wraddress, rdaddress, full, empty,
               almost_full, almost_empty, usedw, rd_valid, overflow, underflow
    );
    modport slave (
        input  wrreq, rdreq,
        output wren, rden, wraddress, rdaddress, full, empty,
               almost_full, almost_empty, usedw, rd_valid, overflow, underflow
    );
`else
    modport master (
        output wrreq, rdreq,
        input  wren, rden, wraddress, rdaddress, full, empty,
               almost_full, almost_empty, usedw, rd_valid
    );
    modport slave (
        input  wrreq, rdreq,
        output wren, rden, wraddress, rdaddress, full, empty,
               almost_full, almost_empty, usedw, rd_valid
    );
`endif
endinterface

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - binary FIFO pointer with increment enable
// Purpose: W-bit wrapping binary counter; MSB acts as the FIFO wrap bit.
// Ports: clock, reset (sync, active-high), inc (advance by one), ptr (current value).
module fifo_ptr #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer/flag controller for the single-clock FIFO
// Purpose: accepts push/pop requests and drives ram_dp_FIFO wren/rden/addresses;
//          reports full/empty/almost flags, fill level and read-data-valid.
// Ports: clock, reset (sync, active-high), bus (fifo_ctrl_if.slave: wrreq, rdreq in;
//        wren, rden, wraddress, rdaddress, full, empty, almost_full, almost_empty,
//        usedw, rd_valid out).
// Option: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags on bus.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int mem_depth = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL  = 28,
    parameter int AE_LEVEL  = 4
) (
    input  logic       clock,
    input  logic       reset,
    fifo_ctrl_if.slave bus
);
    localparam int           AW      = fifo_aw(mem_depth);
    localparam logic [AW:0]  DEPTH_W = (AW+1)'(mem_depth);
    localparam logic [AW:0]  AF_W    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]  AE_W    = (AW+1)'(AE_LEVEL);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] used;
    logic        is_full;
    logic        is_empty;
    logic        wr_acc;
    logic        rd_acc;
    logic        rd_valid_q;

    // Modulo subtraction of wrap-bit pointers yields 0..mem_depth directly.
    assign used     = wr_ptr - rd_ptr;
    assign is_full  = (used == DEPTH_W);
    assign is_empty = (used == '0);

    // Requests in a reset cycle must not touch the RAM or the pointers.
    assign wr_acc = bus.wrreq & ~is_full  & ~reset;
    assign rd_acc = bus.rdreq & ~is_empty & ~reset;

    fifo_ptr #(.W(AW+1)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(AW+1)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    // RAM read latency is one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
        end
    end

    assign bus.wren         = wr_acc;
    assign bus.rden         = rd_acc;
    assign bus.wraddress    = wr_ptr[AW-1:0];
    assign bus.rdaddress    = rd_ptr[AW-1:0];
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (used >= AF_W);
    assign bus.almost_empty = (used <= AE_W);
    assign bus.usedw        = used;
    assign bus.rd_valid     = rd_valid_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (bus.wrreq & is_full);
        underflow_d = underflow_q | (bus.rdreq & is_empty);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule
